// File: rtl/sweep_pair_assembler_pkg.sv
// Shared widths, record layout and tick constants for the sweep pair assembler.
// Also used by the FIFO, which the multi-sensor arbiter will reuse.
package sweep_pair_assembler_pkg;

  localparam int WORD_W   = 17;
  localparam int TS_W     = 24;
  localparam int RECORD_W = 2 * WORD_W + 2 * TS_W;

  // Bit offsets of each field inside a flat record (word_0 in the MSBs).
  localparam int REC_DELTA_LSB = 0;
  localparam int REC_TS_LSB    = REC_DELTA_LSB + TS_W;
  localparam int REC_W1_LSB    = REC_TS_LSB + TS_W;
  localparam int REC_W0_LSB    = REC_W1_LSB + WORD_W;

  localparam int TICKS_PER_US = 96;
  localparam logic [TS_W-1:0] DEF_MIN_PAIR_GAP = TS_W'(10 * TICKS_PER_US);
  localparam logic [TS_W-1:0] DEF_MAX_PAIR_GAP = TS_W'(20000 * TICKS_PER_US);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_SECOND
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] word_0;
    logic [WORD_W-1:0] word_1;
    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   delta;
  } pair_rec_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sweep_pair_assembler_if.sv
// Bundle between the receiver manager, the pair assembler and the readout stage.
// slave = assembler side, master = upstream/downstream environment side.
interface sweep_pair_assembler_if;
  import sweep_pair_assembler_pkg::*;

  logic              data_availible;
  logic [WORD_W-1:0] decoded_data;
  logic [TS_W-1:0]   timestamp_last_data;
  logic [TS_W-1:0]   system_timestamp;
  logic              pair_valid;
  logic              pair_ready;
  logic [WORD_W-1:0] pair_word_0;
  logic [WORD_W-1:0] pair_word_1;
  logic [TS_W-1:0]   pair_timestamp;
  logic [TS_W-1:0]   pair_delta;
  logic [7:0]        dropped_count;
  logic [7:0]        overflow_count;
  logic              waiting;

  modport slave (
    input  data_availible, decoded_data, timestamp_last_data, system_timestamp, pair_ready,
    output pair_valid, pair_word_0, pair_word_1, pair_timestamp, pair_delta,
           dropped_count, overflow_count, waiting
  );

  modport master (
    output data_availible, decoded_data, timestamp_last_data, system_timestamp, pair_ready,
    input  pair_valid, pair_word_0, pair_word_1, pair_timestamp, pair_delta,
           dropped_count, overflow_count, waiting
  );

endinterface

// File: rtl/sweep_pair_fifo.sv
// First-word-fall-through FIFO; head data reads as zero while empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sweep_pair_fifo
  import sweep_pair_assembler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RECORD_W
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign overflow_o = push_i && !push_ok;
  assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sweep_pair_assembler.sv
// Pairs first/second sweep hits into {word_0, word_1, ts_0, delta} records
// and queues them for the readout stage.
module sweep_pair_assembler
  import sweep_pair_assembler_pkg::*;
#(
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [TS_W-1:0] MAX_PAIR_GAP = DEF_MAX_PAIR_GAP,
  parameter logic [TS_W-1:0] MIN_PAIR_GAP = DEF_MIN_PAIR_GAP
) (
  input logic                   clk_96MHz,
  input logic                   reset,
  sweep_pair_assembler_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word0_q, word0_d;
  logic [TS_W-1:0]   ts0_q, ts0_d;
  logic              push_q, push_d;
  pair_rec_t         rec_q, rec_d;
  logic [7:0]        dropped_q, dropped_d;
  logic [7:0]        overflow_q;
  logic              avail_q;

  logic              hit;
  logic [TS_W-1:0]   delta_in;
  logic [TS_W-1:0]   age;
  logic              fifo_empty;
  logic              fifo_ovf;
  pair_rec_t         head;

  // avail_q resets high so a level already present at reset release is not a hit.
  assign hit      = bus.data_availible && !avail_q;
  assign delta_in = bus.timestamp_last_data - ts0_q;
  assign age      = bus.system_timestamp - ts0_q;

  always_comb begin
    state_d   = state_q;
    word0_d   = word0_q;
    ts0_d     = ts0_q;
    push_d    = 1'b0;
    rec_d     = rec_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          word0_d = bus.decoded_data;
          ts0_d   = bus.timestamp_last_data;
          state_d = ST_WAIT_SECOND;
        end
      end
      ST_WAIT_SECOND: begin
        if (hit) begin
          if (delta_in >= MIN_PAIR_GAP && delta_in <= MAX_PAIR_GAP) begin
            push_d  = 1'b1;
            rec_d   = '{word_0: word0_q, word_1: bus.decoded_data,
                        ts: ts0_q, delta: delta_in};
            state_d = ST_IDLE;
          end else if (delta_in > MAX_PAIR_GAP) begin
            // Stale first hit: the new hit becomes the first of a fresh pair.
            dropped_d = sat_inc(dropped_q);
            word0_d   = bus.decoded_data;
            ts0_d     = bus.timestamp_last_data;
          end
        end else if (age > MAX_PAIR_GAP) begin
          dropped_d = sat_inc(dropped_q);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word0_q    <= '0;
      ts0_q      <= '0;
      push_q     <= 1'b0;
      rec_q      <= '0;
      dropped_q  <= '0;
      overflow_q <= '0;
      avail_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      word0_q    <= word0_d;
      ts0_q      <= ts0_d;
      push_q     <= push_d;
      rec_q      <= rec_d;
      dropped_q  <= dropped_d;
      overflow_q <= fifo_ovf ? sat_inc(overflow_q) : overflow_q;
      avail_q    <= bus.data_availible;
    end
  end

  sweep_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RECORD_W)
  ) u_fifo (
    .clk_i      (clk_96MHz),
    .srst_i     (reset),
    .push_i     (push_q),
    .data_i     (rec_q),
    .full_o     (),
    .pop_i      (bus.pair_ready),
    .empty_o    (fifo_empty),
    .data_o     (head),
    .overflow_o (fifo_ovf)
  );

  assign bus.pair_valid     = !fifo_empty;
  assign bus.pair_word_0    = head.word_0;
  assign bus.pair_word_1    = head.word_1;
  assign bus.pair_timestamp = head.ts;
  assign bus.pair_delta     = head.delta;
  assign bus.dropped_count  = dropped_q;
  assign bus.overflow_count = overflow_q;
  assign bus.waiting        = (state_q == ST_WAIT_SECOND);

endmodule

// File: tb/tb_sweep_pair_assembler.sv
// Directed plus randomized checks of the sweep pair assembler against a
// pairing model written from the hit/pair/drop rules.
module tb_sweep_pair_assembler;

  localparam logic [23:0] MIN_GAP = 24'd960;
  localparam logic [23:0] MAX_GAP = 24'd1920000;

  typedef struct packed {
    logic [16:0] w0;
    logic [16:0] w1;
    logic [23:0] ts;
    logic [23:0] d;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sweep_pair_assembler_if bus ();

  sweep_pair_assembler dut (
    .clk_96MHz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  int   compared = 0;
  int   mismatched = 0;
  int   valid_cycles = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t rec_tab[5];

  // Reference pairing state
  bit          m_wait;
  logic [16:0] m_w0;
  logic [23:0] m_t0;
  int          m_drop;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pair_valid) valid_cycles++;
      if (bus.pair_valid && bus.pair_ready)
        got_q.push_back({bus.pair_word_0, bus.pair_word_1, bus.pair_timestamp, bus.pair_delta});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic void model_reset();
    m_wait = 1'b0;
    m_w0   = '0;
    m_t0   = '0;
    m_drop = 0;
    exp_q.delete();
  endfunction

  function automatic void model_hit(input logic [16:0] w, input logic [23:0] ts);
    logic [23:0] d;
    if (!m_wait) begin
      m_wait = 1'b1;
      m_w0   = w;
      m_t0   = ts;
    end else begin
      d = ts - m_t0;
      if (d >= MIN_GAP) begin
        if (d <= MAX_GAP) begin
          exp_q.push_back({m_w0, w, m_t0, d});
          m_wait = 1'b0;
        end else begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          m_w0   = w;
          m_t0   = ts;
        end
      end
    end
  endfunction

  task automatic hit(input logic [16:0] w, input logic [23:0] ts, input int hold);
    bus.decoded_data        = w;
    bus.timestamp_last_data = ts;
    bus.system_timestamp    = ts;
    bus.data_availible      = 1'b1;
    repeat (hold) tick();
    bus.data_availible = 1'b0;
    tick();
    model_hit(w, ts);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {bus.pair_valid, bus.pair_word_0, bus.pair_word_1, bus.pair_timestamp,
                bus.pair_delta, bus.dropped_count, bus.overflow_count, bus.waiting}, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.data_availible = 1'b0;
    tick();
    check_zero("reset_outputs");
    tick();
    reset = 1'b0;
    tick();
    got_q.delete();
    valid_cycles = 0;
    model_reset();
  endtask

  task automatic head_is(input string tag, input rec_t r);
    check(tag, {bus.pair_valid, bus.pair_word_0, bus.pair_word_1, bus.pair_timestamp, bus.pair_delta},
          {1'b1, r});
  endtask

  initial begin
    logic [23:0] t;
    logic [23:0] gap;
    logic [16:0] w;
    int          n;

    bus.data_availible      = 1'b0;
    bus.decoded_data        = '0;
    bus.timestamp_last_data = '0;
    bus.system_timestamp    = '0;
    bus.pair_ready          = 1'b1;
    model_reset();
    repeat (3) tick();
    check_zero("initial_reset");
    reset = 1'b0;
    tick();

    // Basic pair with latency check
    hit(17'h00123, 24'd1000, 1);
    check("basic_waiting", bus.waiting, 1'b1);
    bus.decoded_data        = 17'h1ABCD;
    bus.timestamp_last_data = 24'd50000;
    bus.system_timestamp    = 24'd50000;
    bus.data_availible      = 1'b1;
    tick();
    check("basic_valid_t1", bus.pair_valid, 1'b0);
    bus.data_availible = 1'b0;
    tick();
    head_is("basic_head_t2", {17'h00123, 17'h1ABCD, 24'd1000, 24'd49000});
    repeat (3) tick();
    check("basic_valid_cycles", valid_cycles, 1);
    check("basic_count", got_q.size(), 1);
    check("basic_counters", {bus.dropped_count, bus.overflow_count, bus.waiting}, '0);

    // Timestamp wrap-around
    hit(17'h0AAAA, 24'hFFFF00, 1);
    hit(17'h15555, 24'h000500, 1);
    repeat (3) tick();
    check("wrap_count", got_q.size(), 2);
    if (got_q.size() >= 2) check("wrap_rec", got_q[1], {17'h0AAAA, 17'h15555, 24'hFFFF00, 24'h000600});

    // Duplicate then timeout
    hit(17'h01111, 24'h100000, 1);
    hit(17'h02222, 24'h100000 + 24'd500, 1);
    check("dup_waiting", bus.waiting, 1'b1);
    bus.system_timestamp = 24'h100000 + MAX_GAP;
    tick();
    tick();
    check("timeout_edge_waiting", bus.waiting, 1'b1);
    bus.system_timestamp = 24'h100000 + MAX_GAP + 24'd1;
    tick();
    check("timeout_waiting", bus.waiting, 1'b0);
    check("timeout_dropped", bus.dropped_count, 8'd1);
    tick();
    check("timeout_no_record", got_q.size(), 2);

    // Gap boundaries: 959 ignored, 960 accepted, MAX+1 drops, MAX accepted
    t = 24'h400000;
    hit(17'h00A0A, t, 1);
    hit(17'h00B0B, t + 24'd959, 1);
    hit(17'h00C0C, t + 24'd960, 1);
    t = 24'h600000;
    hit(17'h00D0D, t, 1);
    hit(17'h00E0E, t + MAX_GAP + 24'd1, 1);
    check("drop_latch_waiting", bus.waiting, 1'b1);
    hit(17'h00F0F, t + MAX_GAP + 24'd1 + MAX_GAP, 1);
    repeat (3) tick();
    check("bound_count", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      check("bound_min_rec", got_q[2], {17'h00A0A, 17'h00C0C, 24'h400000, 24'd960});
      check("bound_max_rec", got_q[3], {17'h00E0E, 17'h00F0F, t + MAX_GAP + 24'd1, MAX_GAP});
    end
    check("bound_dropped", bus.dropped_count, 8'd2);

    // Overflow: five pairs into a four-deep FIFO with no consumer
    do_reset();
    bus.pair_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rec_tab[i] = {17'(i * 3 + 1), 17'(i * 5 + 2), 24'h200000 + 24'(i * 100000), 24'(5000 + i)};
      hit(rec_tab[i].w0, rec_tab[i].ts, 1);
      hit(rec_tab[i].w1, rec_tab[i].ts + rec_tab[i].d, 1);
    end
    repeat (3) tick();
    check("ovf_count", bus.overflow_count, 8'd1);
    head_is("ovf_head", rec_tab[0]);
    bus.pair_ready = 1'b1;
    repeat (8) tick();
    check("ovf_drained", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check($sformatf("ovf_rec%0d", i), got_q[i], rec_tab[i]);
    check("ovf_empty", bus.pair_valid, 1'b0);

    // Full FIFO with a pop on the same cycle as the fifth write
    do_reset();
    bus.pair_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit(rec_tab[i].w0, rec_tab[i].ts, 1);
      hit(rec_tab[i].w1, rec_tab[i].ts + rec_tab[i].d, 1);
    end
    repeat (3) tick();
    hit(rec_tab[4].w0, rec_tab[4].ts, 1);
    bus.decoded_data        = rec_tab[4].w1;
    bus.timestamp_last_data = rec_tab[4].ts + rec_tab[4].d;
    bus.system_timestamp    = rec_tab[4].ts + rec_tab[4].d;
    bus.data_availible      = 1'b1;
    tick();
    bus.data_availible = 1'b0;
    bus.pair_ready     = 1'b1;
    tick();
    bus.pair_ready = 1'b0;
    tick();
    check("fullpop_no_ovf", bus.overflow_count, 8'd0);
    check("fullpop_one_popped", got_q.size(), 1);
    head_is("fullpop_head", rec_tab[1]);
    bus.pair_ready = 1'b1;
    repeat (8) tick();
    check("fullpop_total", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check($sformatf("fullpop_rec%0d", i), got_q[i], rec_tab[i]);

    // Held level: one event only; level already high at reset release gives none
    do_reset();
    hit(17'h0F0F0, 24'h300000, 1);
    hit(17'h00F0F, 24'h300000 + 24'd1000, 10);
    repeat (3) tick();
    check("held_waiting", bus.waiting, 1'b0);
    check("held_records", got_q.size(), 1);
    reset = 1'b1;
    bus.data_availible = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("held_at_release", bus.waiting, 1'b0);
    bus.data_availible = 1'b0;
    tick();

    // Reset mid-pair discards the partial pair and buffered records
    do_reset();
    bus.pair_ready = 1'b0;
    hit(17'h00111, 24'h010000, 1);
    hit(17'h00222, 24'h010000 + 24'd2000, 1);
    hit(17'h00333, 24'h020000, 1);
    repeat (2) tick();
    check("mid_pre_state", {bus.pair_valid, bus.waiting}, 2'b11);
    reset = 1'b1;
    tick();
    check_zero("mid_reset_outputs");
    reset = 1'b0;
    tick();
    got_q.delete();
    model_reset();
    bus.pair_ready = 1'b1;
    hit(17'h01234, 24'h500000, 1);
    hit(17'h04321, 24'h500000 + 24'd3000, 1);
    repeat (3) tick();
    check("mid_after_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("mid_after_rec", got_q[0], {17'h01234, 17'h04321, 24'h500000, 24'd3000});

    // Randomized hit stream against the reference model
    do_reset();
    t = 24'($urandom);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    gap = 24'($urandom_range(0, 959));
        2:       gap = 24'($urandom_range(1920001, 2600000));
        3:       gap = ($urandom_range(0, 1) == 0) ? MIN_GAP : MAX_GAP;
        default: gap = 24'($urandom_range(960, 1920000));
      endcase
      t = t + gap;
      w = 17'($urandom);
      hit(w, t, $urandom_range(1, 3));
    end
    repeat (4) tick();
    check("rand_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("rand_rec%0d", i), got_q[i], exp_q[i]);
    check("rand_dropped", bus.dropped_count, 8'(m_drop));
    check("rand_overflow", bus.overflow_count, 8'd0);
    check("rand_waiting", bus.waiting, m_wait);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
